// File: rtl/mem_ctrl_pkg.sv
// Shared CPU defines for the memory controller: access sizes, FSM states and I/O region prefix.
package mem_ctrl_pkg;
  localparam logic [1:0] SZ_B      = 2'b00;
  localparam logic [1:0] SZ_H      = 2'b01;
  localparam logic [1:0] SZ_W      = 2'b10;
  localparam logic [1:0] IO_PREFIX = 2'b11;

  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction
endpackage

// File: rtl/mem_ctrl_if.sv
// Memory bus plus fetch and load/store requester handshakes of the memory controller.
interface mem_ctrl_if;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_valid_in;
  logic [31:0] if_addr_in;
  logic        if_done_out;
  logic [31:0] if_data_out;
  logic        ls_valid_in;
  logic        ls_wr_in;
  logic [1:0]  ls_size_in;
  logic [31:0] ls_addr_in;
  logic [31:0] ls_data_in;
  logic        ls_done_out;
  logic [31:0] ls_data_out;

  modport slave (
    input  mem_din, if_valid_in, if_addr_in, ls_valid_in, ls_wr_in, ls_size_in,
           ls_addr_in, ls_data_in,
    output mem_dout, mem_a, mem_wr, if_done_out, if_data_out, ls_done_out, ls_data_out
  );
  modport master (
    output mem_din, if_valid_in, if_addr_in, ls_valid_in, ls_wr_in, ls_size_in,
           ls_addr_in, ls_data_in,
    input  mem_dout, mem_a, mem_wr, if_done_out, if_data_out, ls_done_out, ls_data_out
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and load/store onto an 8-bit bus.
// Loads have priority; the I/O write buffer and debug pause can stall the byte sequence.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      rdy_in,
  input  logic      io_buffer_full,
  input  logic      flush_in,
  mem_ctrl_if.slave bus
);
  state_e      state_q, state_d;
  logic [2:0]  n_q, n_d, a_q, a_d, c_q, c_d, c_nxt, a_nxt;
  logic        pend_q, pend_d, wr_q, wr_d, ifd_q, ifd_d, lsd_q, lsd_d;
  logic [31:0] base_q, base_d, wdat_q, wdat_d, data_q, data_d, addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic        io_blk;

  assign io_blk = (addr_q[RAM_ADDR_WIDTH -: 2] == IO_PREFIX) && io_buffer_full;

  assign bus.mem_a       = addr_q;
  assign bus.mem_dout    = dout_q;
  assign bus.mem_wr      = wr_q & rdy_in & ~io_blk;
  assign bus.if_done_out = ifd_q;
  assign bus.ls_done_out = lsd_q;
  assign bus.if_data_out = data_q;
  assign bus.ls_data_out = data_q;

  // a_q: byte index on mem_a; c_q: next byte to capture; pend_q: mem_din holds byte c_q.
  always_comb begin
    state_d = state_q; n_d = n_q; a_d = a_q; c_d = c_q; pend_d = pend_q;
    wr_d = wr_q; base_d = base_q; wdat_d = wdat_q; data_d = data_q;
    addr_d = addr_q; dout_d = dout_q; ifd_d = ifd_q; lsd_d = lsd_q;
    c_nxt = c_q + {2'b00, pend_q};
    a_nxt = a_q + 3'd1;
    if (rdy_in) begin
      ifd_d = 1'b0;
      lsd_d = 1'b0;
      case (state_q)
        IDLE: if (!ifd_q && !lsd_q) begin
          if (bus.ls_valid_in) begin
            base_d = bus.ls_addr_in; addr_d = bus.ls_addr_in;
            n_d = size_bytes(bus.ls_size_in);
            a_d = '0; c_d = '0; pend_d = 1'b0; data_d = '0;
            if (bus.ls_wr_in) begin
              state_d = LS_WR; wr_d = 1'b1;
              wdat_d = bus.ls_data_in; dout_d = bus.ls_data_in[7:0];
            end else begin
              state_d = LS_RD;
            end
          end else if (bus.if_valid_in && !flush_in) begin
            base_d = bus.if_addr_in; addr_d = bus.if_addr_in; n_d = 3'd4;
            a_d = '0; c_d = '0; pend_d = 1'b0; data_d = '0;
            state_d = IF_RD;
          end
        end
        IF_RD, LS_RD: begin
          if (state_q == IF_RD && flush_in) begin
            state_d = IDLE; addr_d = '0; a_d = '0; c_d = '0; pend_d = 1'b0;
          end else begin
            if (pend_q) data_d[{c_q[1:0], 3'b000} +: 8] = bus.mem_din;
            if (c_nxt == n_q) begin
              state_d = IDLE; addr_d = '0; a_d = '0; c_d = '0; pend_d = 1'b0;
              if (state_q == IF_RD) ifd_d = 1'b1;
              else                  lsd_d = 1'b1;
            end else begin
              c_d    = c_nxt;
              pend_d = (a_q < n_q);
              if (a_q < n_q) a_d = a_nxt;
              addr_d = (a_nxt < n_q) ? base_q + 32'(a_nxt) : '0;
            end
          end
        end
        LS_WR: if (!io_blk) begin
          if (a_nxt == n_q) begin
            state_d = IDLE; wr_d = 1'b0; addr_d = '0; dout_d = '0; a_d = '0; lsd_d = 1'b1;
          end else begin
            a_d    = a_nxt;
            addr_d = base_q + 32'(a_nxt);
            dout_d = wdat_q[{a_nxt[1:0], 3'b000} +: 8];
          end
        end
        default: ;
      endcase
    end else if (state_q == IF_RD || state_q == LS_RD) begin
      // Paused reads rewind to the oldest uncaptured byte so it is re-read on resume.
      a_d    = c_q;
      pend_d = 1'b0;
      addr_d = base_q + 32'(c_q);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE; n_q <= '0; a_q <= '0; c_q <= '0; pend_q <= 1'b0;
      wr_q <= 1'b0; ifd_q <= 1'b0; lsd_q <= 1'b0; base_q <= '0; wdat_q <= '0;
      data_q <= '0; addr_q <= '0; dout_q <= '0;
    end else begin
      state_q <= state_d; n_q <= n_d; a_q <= a_d; c_q <= c_d; pend_q <= pend_d;
      wr_q <= wr_d; ifd_q <= ifd_d; lsd_q <= lsd_d; base_q <= base_d; wdat_q <= wdat_d;
      data_q <= data_d; addr_q <= addr_d; dout_q <= dout_d;
    end
  end
endmodule
